wrr_arbiter: RTL
================

Name: wrr_arbiter

Overview:
- Parametrised weighted round-robin arbiter with per-channel burst credits, grant locking and clock enable.
- Sits in front of shared buses and memory ports where requesters need unequal bandwidth shares.
- A granted channel keeps ownership for up to weight[g] consecutive cycles while it requests, or indefinitely while its lock is held.
- Arbitration then rotates to the next requester after the current owner.

Parameters:
- N, 8, number of requesting channels (2..32).
- WW, 4, width of each per-channel weight field.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ce  in  1  clock enable; when low all state holds
- req  in  N  request, one bit per channel
- lock  in  N  lock; lock[g] high holds the current grant for owner g
- weight  in  N*WW  weight of channel i in bits [i*WW +: WW]; 0 is treated as 1
- sel  out  N  registered one-hot grant; 0 when idle
- sel_enc  out  $clog2(N)+1  encoded grant; all ones when idle
- gnt_new  out  1  one-cycle pulse when a new grant (including a re-grant) takes effect on sel

Behaviour:
- Reset values: sel=0, sel_enc=all ones, gnt_new=0, state=IDLE, cnt=0, ptr=N-1 (first search starts at channel 0).
- Internal state: 2-state FSM (IDLE, BUSY), owner index g, credit counter cnt (WW bits), pointer ptr = last granted index.
- Circular search S(p): the first i with req[i] set, scanning p+1, p+2, … wrapping through p itself last.
- All transitions are qualified by ce. With ce=0, sel, sel_enc, cnt, ptr and state hold, and gnt_new=0.
- Latency: a request sampled at edge k appears on sel after edge k (one registered stage).
- IDLE:
  - If req==0, stay in IDLE.
  - Else grant g=S(ptr): sel<=onehot(g), sel_enc<=g, gnt_new<=1, ptr<=g, cnt<=max(weight[g],1)-1, go to BUSY.
- BUSY, evaluated in priority order:
  1. lock[g]=1: hold grant; cnt unchanged; gnt_new=0. This applies even if req[g]=0.
  2. req[g]=1 and cnt!=0: hold grant; cnt<=cnt-1.
  3. Otherwise re-arbitrate with S(g):
     - If a requester is found, grant it with a fresh credit load and gnt_new=1.
     - A sole requester g therefore re-grants itself with reloaded credits.
     - If req==0, go to IDLE: sel<=0, sel_enc<=all ones, gnt_new<=0.
- Only bits of lock matching the owner matter; lock bits of non-owners are ignored.
- Weight is sampled only at grant time; changes mid-burst take effect at the next grant.
- Hold cycles per grant = max(weight,1), counting the grant cycle.
- sel is always one-hot or zero; sel_enc always agrees with sel.
- Reset mid-burst returns to the reset values on the next edge regardless of ce, lock or req.
- With N not a power of two, the pointer wraps from N-1 to 0; index values ≥N never appear.

Test Plan (N=4, WW=3):
- Reset, then hold req=0 for 3 cycles -> sel=0000, sel_enc=3'b111, gnt_new=0 throughout.
- All weights=1, req=1111 constant -> sel cycles 0001,0010,0100,1000,0001; sel_enc 0,1,2,3,0; gnt_new high every cycle.
- weight0=3, weight1=0, req=0011 -> sel 0001×3, 0010×1, 0001×3; gnt_new only on the first cycle of each burst.
- Channel 2 granted with weight 1, lock=0100 for 5 cycles, req=1111 -> sel stays 0100 for 6 cycles total, then 1000 the cycle after lock drops.
- Mid-burst on channel 0 (weight 4), ce=0 for 3 cycles -> sel and cnt frozen; resumes and finishes the remaining credits once ce=1.
- Channel 0 granted (weight 4); req[0] drops after 1 cycle with req=0100 -> next sel=0100, gnt_new=1.
  - Then req=0 -> sel=0000, sel_enc=111.
  - Then assert rst during a locked burst -> reset values next cycle.

Source files
------------

// File: rtl/wrr_arbiter.sv
// rtl/wrr_arbiter.sv - weighted round-robin arbiter with burst credits, grant lock and clock enable
// One registered stage: a request sampled at an edge shows up on sel right after that edge.
module wrr_arbiter #(
    parameter int N  = 8,
    parameter int WW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          lock,
    input  logic [N*WW-1:0]       weight,
    output logic [N-1:0]          sel,
    output logic [$clog2(N):0]    sel_enc,
    output logic                  gnt_new
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_sel;
    logic [IW:0]     r_enc;
    logic            r_gnt_new;
    logic [WW-1:0]   r_cnt;
    logic [IW-1:0]   r_ptr;

    state_t          w_state_nxt;
    logic [N-1:0]    w_sel_nxt;
    logic [IW:0]     w_enc_nxt;
    logic            w_gnt_nxt;
    logic [WW-1:0]   w_cnt_nxt;
    logic [IW-1:0]   w_ptr_nxt;

    logic            w_found;
    logic [IW-1:0]   w_next;
    logic [IW-1:0]   w_idx;
    logic [WW-1:0]   w_wsel;
    logic [WW-1:0]   w_load;
    int              w_sum;

    // Circular search from the last grant: ptr+1 first, ptr itself last.
    // r_ptr always equals the current owner while BUSY, so one search serves both states.
    always_comb begin
        w_found = 1'b0;
        w_next  = r_ptr;
        w_idx   = r_ptr;
        w_sum   = 0;
        for (int k = 1; k <= N; k++) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_idx = IW'(w_sum);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_next  = w_idx;
            end
        end
    end

    // Credit load for the candidate; a zero weight still grants one cycle.
    always_comb begin
        w_wsel = '0;
        for (int i = 0; i < N; i++) begin
            if (w_next == IW'(i)) begin
                w_wsel = weight[i*WW +: WW];
            end
        end
        w_load = (w_wsel == '0) ? '0 : (w_wsel - WW'(1));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_enc_nxt   = r_enc;
        w_gnt_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt         = BUSY;
                    w_sel_nxt           = '0;
                    w_sel_nxt[w_next]   = 1'b1;
                    w_enc_nxt           = {1'b0, w_next};
                    w_gnt_nxt           = 1'b1;
                    w_ptr_nxt           = w_next;
                    w_cnt_nxt           = w_load;
                end
            end
            BUSY: begin
                if (lock[r_ptr]) begin
                    w_state_nxt = BUSY;
                end else if (req[r_ptr] && (r_cnt != '0)) begin
                    w_cnt_nxt = r_cnt - WW'(1);
                end else if (w_found) begin
                    w_sel_nxt           = '0;
                    w_sel_nxt[w_next]   = 1'b1;
                    w_enc_nxt           = {1'b0, w_next};
                    w_gnt_nxt           = 1'b1;
                    w_ptr_nxt           = w_next;
                    w_cnt_nxt           = w_load;
                end else begin
                    w_state_nxt = IDLE;
                    w_sel_nxt   = '0;
                    w_enc_nxt   = '1;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = '0;
                w_enc_nxt   = '1;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // gnt_new is a pulse: it drops on any frozen cycle rather than holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_enc     <= '1;
            r_gnt_new <= 1'b0;
            r_cnt     <= '0;
            r_ptr     <= IW'(N - 1);
        end else if (ce) begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_enc     <= w_enc_nxt;
            r_gnt_new <= w_gnt_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
        end else begin
            r_gnt_new <= 1'b0;
        end
    end

    assign sel     = r_sel;
    assign sel_enc = r_enc;
    assign gnt_new = r_gnt_new;

endmodule
